hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Per-register write scoreboard for the pipelined core; replaces fixed-distance hazard checks once loads/mul/div have variable latency.
//  Decode presents an issuing instruction; block counts in-flight writes per architectural register and raises stall_d on RAW/WAW hazards.
//  Writeback/kill ports retire entries; same-cycle writeback result is bypassed to decode instead of stalling. Sits beside the decode stage.
// PARAMETERS
//  NREG      32  number of architectural registers (x0 hardwired zero, never tracked)
//  REG_AW     5  register index width, = $clog2(NREG)
//  MAX_INFL   3  max in-flight writes to one register; counter width CNT_W = $clog2(MAX_INFL+1)
// PORTS
//  clk            in   1       core clock, all state on rising edge
//  reset          in   1       asynchronous, active-high reset
//  iss_valid      in   1       decode holds a valid instruction attempting issue
//  iss_rs1        in   REG_AW  source 1 index
//  iss_rs1_use    in   1       instruction reads rs1
//  iss_rs2        in   REG_AW  source 2 index
//  iss_rs2_use    in   1       instruction reads rs2
//  iss_rd         in   REG_AW  destination index
//  iss_we         in   1       instruction writes rd
//  wb_valid       in   1       writeback retiring a register write this cycle
//  wb_rd          in   REG_AW  writeback destination
//  kill_valid     in   1       flushed in-flight instruction releasing its rd
//  kill_rd        in   REG_AW  killed destination
//  stall_d        out  1       hold fetch/decode; issue does not take effect
//  fwd_a          out  1       select writeback result for rs1 this cycle
//  fwd_b          out  1       select writeback result for rs2 this cycle
//  sb_idle        out  1       no register pending (fence/CSR drain)
//  sb_err         out  1       sticky: decrement of zero counter observed
//  perf_stall_cnt out  32      stall cycles (only with SB_PERF_EN)
// BEHAVIOUR
//  - Reset: all counters 0, sb_err 0, perf_stall_cnt 0; outputs combinational from state: stall_d 0, fwd_a/b 0, sb_idle 1.
//  - pend[r] = counter of r; index 0 ignored on every port (reads as 0, never inc/dec).
//  - Source hazard on rsN: use && rsN!=0 && pend[rsN]!=0, unless pend[rsN]==1 && wb_valid && wb_rd==rsN -> no hazard, fwd_N=1.
//  - fwd_N asserted only when iss_valid; 0 otherwise.
//  - WAW/structural: iss_we && rd!=0 && pend[rd]==MAX_INFL -> stall.
//  - stall_d = iss_valid && (src hazard rs1 || src hazard rs2 || structural). Pure combinational, zero latency.
//  - Issue fires when iss_valid && !stall_d: pend[rd] += 1 if iss_we && rd!=0, visible next cycle.
//  - wb_valid: pend[wb_rd] -= 1; kill_valid: pend[kill_rd] -= 1; both same cycle same rd -> -2.
//  - Net update per register = inc - decs in one cycle (issue+wb same rd -> unchanged).
//  - Underflow: decrement below 0 clamps at 0 and sets sb_err until reset.
//  - Overflow impossible by structural stall; not checked separately.
//  - sb_idle = all pend==0 (registered state, not including this cycle's issue).
//  - Reset mid-operation: all pending state discarded immediately; caller flushes pipeline concurrently.
// CONFIGURATION
//  SB_PERF_EN defined: perf_stall_cnt increments every cycle stall_d=1, saturates at 32'hFFFF_FFFF, cleared by reset.
//  SB_PERF_EN undefined: perf_stall_cnt tied to 0, counter logic absent.
// STRUCTURE
//  Package hazard_sb_pkg: REG_AW default, CNT_W function, reg_idx_t typedef, ZERO_REG constant.
//  Sub-module sb_entry: one counter (inc, dec0, dec1 inputs; clamp, underflow flag, nonzero out), generated for r=1..NREG-1.
//  Top: hazard compare, stall/forward logic, idle OR-reduce, err OR-reduce, optional perf counter.
// TESTING
//  Issue x5 write, next cycle reader of x5 (wb not yet) -> stall_d=1 until wb_rd=5 cycle, then fwd_a=1, stall_d=0.
//  Issue three writes to x7 (MAX_INFL=3), fourth write to x7 -> stall_d=1; wb_rd=7 -> next cycle fourth issues.
//  Issue write x9 with wb_rd=9 same cycle, pend[9]=1 before -> pend[9] stays 1, sb_idle=0.
//  Reader of x0 / write to x0 with arbitrary wb traffic -> never stall, sb_idle unaffected.
//  wb_valid with wb_rd=4, pend[4]=0 -> pend stays 0, sb_err=1 sticky; reset -> sb_err=0, sb_idle=1.
//  SB_PERF_EN: 10 stalled cycles -> perf_stall_cnt=10; without macro -> 0.

Source files
------------

// File: rtl/hazard_sb_pkg.sv
// Shared types and sizing helpers for the per-register write scoreboard.
package hazard_sb_pkg;

    localparam int NREG_DEFAULT     = 32;
    localparam int REG_AW_DEFAULT   = 5;
    localparam int MAX_INFL_DEFAULT = 3;

    typedef logic [REG_AW_DEFAULT-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

    function automatic int calcCntW(input int maxInfl);
        return $clog2(maxInfl + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/kill bundle between the pipeline and the hazard scoreboard.
interface hazard_scoreboard_if
    import hazard_sb_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
);

    logic              iss_valid;
    logic [REG_AW-1:0] iss_rs1;
    logic              iss_rs1_use;
    logic [REG_AW-1:0] iss_rs2;
    logic              iss_rs2_use;
    logic [REG_AW-1:0] iss_rd;
    logic              iss_we;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              kill_valid;
    logic [REG_AW-1:0] kill_rd;
    logic              stall_d;
    logic              fwd_a;
    logic              fwd_b;
    logic              sb_idle;
    logic              sb_err;
    logic [31:0]       perf_stall_cnt;

    modport master (
        output iss_valid, iss_rs1, iss_rs1_use, iss_rs2, iss_rs2_use, iss_rd, iss_we,
        output wb_valid, wb_rd, kill_valid, kill_rd,
        input  stall_d, fwd_a, fwd_b, sb_idle, sb_err, perf_stall_cnt
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs1_use, iss_rs2, iss_rs2_use, iss_rd, iss_we,
        input  wb_valid, wb_rd, kill_valid, kill_rd,
        output stall_d, fwd_a, fwd_b, sb_idle, sb_err, perf_stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One in-flight write counter: +1 issue, -1 per retire/kill, clamps at zero with sticky error.
module sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec0,
    input  logic             dec1,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero,
    output logic             err
);

    localparam int SW = CNT_W + 2;

    logic signed [SW-1:0] sumP0;
    logic                 underflowP0;
    logic [CNT_W-1:0]     cntNextP0;

    always_comb begin
        sumP0 = $signed({2'b00, cnt}) + $signed(SW'(inc))
              - $signed(SW'(dec0)) - $signed(SW'(dec1));
        underflowP0 = (sumP0 < 0);
        cntNextP0   = underflowP0 ? '0 : sumP0[CNT_W-1:0];
    end

    // p0 -> state: counter and sticky underflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cntNextP0;
            if (underflowP0) err <= 1'b1;
        end
    end

    assign nonzero = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard beside decode: RAW/WAW stall, writeback bypass select, idle/error status.
// Optional stall-cycle counter enabled by defining SB_PERF_EN.
module hazard_scoreboard
    import hazard_sb_pkg::*;
#(
    parameter int NREG     = NREG_DEFAULT,
    parameter int REG_AW   = REG_AW_DEFAULT,
    parameter int MAX_INFL = MAX_INFL_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    hazard_scoreboard_if.slave sb
);

    localparam int               CNT_W   = calcCntW(MAX_INFL);
    localparam int               NSLOT   = 1 << REG_AW;
    localparam logic [REG_AW-1:0] ZIDX    = REG_AW'(ZERO_REG);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFL);

    logic [CNT_W-1:0] pend [NSLOT];
    logic [NSLOT-1:0] nzVec;
    logic [NSLOT-1:0] errVec;

    logic rs1Live, rs2Live, rs1Byp, rs2Byp, rs1Haz, rs2Haz, wawHaz;
    logic stall, issFire;

    // A single pending write retiring this very cycle is bypassed rather than stalled on.
    always_comb begin
        rs1Live = sb.iss_rs1_use && (sb.iss_rs1 != ZIDX);
        rs2Live = sb.iss_rs2_use && (sb.iss_rs2 != ZIDX);
        rs1Byp  = rs1Live && (pend[sb.iss_rs1] == CNT_ONE) && sb.wb_valid && (sb.wb_rd == sb.iss_rs1);
        rs2Byp  = rs2Live && (pend[sb.iss_rs2] == CNT_ONE) && sb.wb_valid && (sb.wb_rd == sb.iss_rs2);
        rs1Haz  = rs1Live && (pend[sb.iss_rs1] != '0) && !rs1Byp;
        rs2Haz  = rs2Live && (pend[sb.iss_rs2] != '0) && !rs2Byp;
        wawHaz  = sb.iss_we && (sb.iss_rd != ZIDX) && (pend[sb.iss_rd] == CNT_MAX);
        stall   = sb.iss_valid && (rs1Haz || rs2Haz || wawHaz);
        issFire = sb.iss_valid && !stall;
    end

    assign sb.stall_d = stall;
    assign sb.fwd_a   = sb.iss_valid && rs1Byp;
    assign sb.fwd_b   = sb.iss_valid && rs2Byp;
    assign sb.sb_idle = ~|nzVec;
    assign sb.sb_err  = |errVec;

    // x0 and indices beyond NREG have no counter and read as never pending.
    for (genvar r = 0; r < NSLOT; r++) begin : gSlot
        if (r == 0 || r >= NREG) begin : gNone
            assign pend[r]   = '0;
            assign nzVec[r]  = 1'b0;
            assign errVec[r] = 1'b0;
        end else begin : gEntry
            localparam logic [REG_AW-1:0] IDX = REG_AW'(r);
            sb_entry #(.CNT_W(CNT_W)) uEntry (
                .clk     (clk),
                .reset   (reset),
                .inc     (issFire && sb.iss_we && (sb.iss_rd == IDX)),
                .dec0    (sb.wb_valid && (sb.wb_rd == IDX)),
                .dec1    (sb.kill_valid && (sb.kill_rd == IDX)),
                .cnt     (pend[r]),
                .nonzero (nzVec[r]),
                .err     (errVec[r])
            );
        end
    end

`ifdef SB_PERF_EN
    logic [31:0] perfCnt;

    // stall -> counter: saturating count of stalled decode cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perfCnt <= '0;
        end else if (stall && (perfCnt != 32'hFFFF_FFFF)) begin
            perfCnt <= perfCnt + 32'd1;
        end
    end

    assign sb.perf_stall_cnt = perfCnt;
`else
    assign sb.perf_stall_cnt = '0;
`endif

endmodule
